// File: rtl/switch_ingress_router_pkg.sv
// ----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the switch ingress router:
//   - sw_rt_state_t : router FSM states
//   - HDR_*         : header byte offsets within a packet (DA, SA, LEN), plus
//                     an extra index marking the payload phase
//   - PORT_ADDR_DEF : default destination address of each output port
//   - packPortAddr  : packs PORT_ADDR_DEF into the flat port_addr bus layout
// No ports (package).
// ----------------------------------------------------------------------------
package switch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DA_WR,
    ST_SA,
    ST_LEN,
    ST_PAYLOAD,
    ST_DROP
  } sw_rt_state_t;

  // Header position tracker. HDR_BODY is not a real header offset; it marks
  // that the header has been consumed and payload bytes are being counted.
  typedef logic [1:0] hdr_idx_t;

  localparam hdr_idx_t HDR_DA   = 2'd0;
  localparam hdr_idx_t HDR_SA   = 2'd1;
  localparam hdr_idx_t HDR_LEN  = 2'd2;
  localparam hdr_idx_t HDR_BODY = 2'd3;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_W_WIDTH   = 8;

  localparam logic [DEF_W_WIDTH-1:0] PORT_ADDR_DEF [DEF_NUM_PORTS] =
    '{8'h10, 8'h20, 8'h30, 8'h40};

  // Port i's address lands at [i*W +: W], matching the router's port_addr bus.
  function automatic logic [DEF_NUM_PORTS*DEF_W_WIDTH-1:0] packPortAddr();
    logic [DEF_NUM_PORTS*DEF_W_WIDTH-1:0] packed_addr;
    packed_addr = '0;
    for (int i = 0; i < DEF_NUM_PORTS; i++) begin
      packed_addr[i*DEF_W_WIDTH +: DEF_W_WIDTH] = PORT_ADDR_DEF[i];
    end
    return packed_addr;
  endfunction

endpackage

// File: rtl/switch_ingress_router_if.sv
// ----------------------------------------------------------------------------
// switch_ingress_router_if
// Byte-stream ingress handshake plus the shared write bus to the per-port
// output FIFOs.
//   in_data    : ingress byte
//   in_valid   : in_data valid
//   in_ready   : byte accepted when in_valid && in_ready
//   fifo_full  : full flag of each output FIFO
//   fifo_wr_en : one-hot-or-zero write strobe per FIFO
//   fifo_data  : shared write data to all FIFOs
// Modports:
//   master : the environment (packet source and FIFOs)
//   slave  : the router
// ----------------------------------------------------------------------------
interface switch_ingress_router_if #(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 8
) ();

  logic [W_WIDTH-1:0]   in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_wr_en;
  logic [W_WIDTH-1:0]   fifo_data;

  modport master (
    output in_data,
    output in_valid,
    output fifo_full,
    input  in_ready,
    input  fifo_wr_en,
    input  fifo_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  fifo_full,
    output in_ready,
    output fifo_wr_en,
    output fifo_data
  );

endinterface

// File: rtl/switch_ingress_router_addr_match.sv
// ----------------------------------------------------------------------------
// switch_addr_match
// Compares a destination address against every port address and returns the
// lowest-numbered matching port.
//   da_i        : destination address byte under test
//   port_addr_i : flat port addresses, port i at [i*W_WIDTH +: W_WIDTH]
//   match_o     : at least one port address equals da_i
//   sel_o       : index of the lowest matching port (0 when no match)
// Purely combinational.
// ----------------------------------------------------------------------------
module switch_addr_match
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 8,
  parameter int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [W_WIDTH-1:0]           da_i,
  input  logic [NUM_PORTS*W_WIDTH-1:0] port_addr_i,
  output logic                         match_o,
  output logic [SEL_WIDTH-1:0]         sel_o
);

  // Priority encoder: scanning from the highest port down lets the lowest
  // matching port overwrite any higher one, so duplicated addresses resolve
  // to the smallest index.
  always_comb begin
    match_o = 1'b0;
    sel_o   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_addr_i[i*W_WIDTH +: W_WIDTH] == da_i) begin
        match_o = 1'b1;
        sel_o   = SEL_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/switch_ingress_router.sv
// ----------------------------------------------------------------------------
// switch_ingress_router
// Ingress stage of the switch. Takes one byte stream of packets
// (DA, SA, LEN, LEN payload bytes), looks up DA against the port address
// table and writes the whole packet into exactly one output FIFO. Packets
// whose DA matches no port are consumed and dropped.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   bus       : ingress handshake and FIFO write bus (slave modport)
//   port_addr : DA of port i at [i*W_WIDTH +: W_WIDTH], static within a packet
//   busy      : high whenever the FSM is not idle
//   fwd_cnt   : saturating count of fully forwarded packets
//   drop_cnt  : saturating count of dropped packets
// ----------------------------------------------------------------------------
module switch_ingress_router
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  switch_ingress_router_if.slave       bus,
  input  logic [NUM_PORTS*W_WIDTH-1:0] port_addr,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         fwd_cnt,
  output logic [CNT_WIDTH-1:0]         drop_cnt
);

  localparam int SEL_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  sw_rt_state_t         state_q,   state_d;
  logic [SEL_WIDTH-1:0] sel_q,     sel_d;
  logic [W_WIDTH-1:0]   da_q,      da_d;
  logic [W_WIDTH-1:0]   lenCnt_q,  lenCnt_d;
  hdr_idx_t             hdrIdx_q,  hdrIdx_d;
  logic [CNT_WIDTH-1:0] fwdCnt_q;
  logic [CNT_WIDTH-1:0] dropCnt_q;

  logic                 inReady;
  logic                 accept;
  logic [NUM_PORTS-1:0] wrEn;
  logic [W_WIDTH-1:0]   wrData;
  logic                 fwdInc;
  logic                 dropInc;
  logic                 daMatch;
  logic [SEL_WIDTH-1:0] daSel;

  // DA lookup runs straight off the ingress byte so the routing decision is
  // ready in the same cycle the DA is accepted.
  switch_addr_match #(
    .NUM_PORTS (NUM_PORTS),
    .W_WIDTH   (W_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_addr_match (
    .da_i        (bus.in_data),
    .port_addr_i (port_addr),
    .match_o     (daMatch),
    .sel_o       (daSel)
  );

  // Ready generation. IDLE and DROP never stall. DA_WR is the bubble cycle
  // in which the registered DA goes out, so no new byte can be taken. While
  // passing bytes through, readiness simply mirrors the selected FIFO so a
  // full FIFO backpressures the stream instead of losing data.
  always_comb begin
    inReady = 1'b0;
    unique case (state_q)
      ST_IDLE:    inReady = 1'b1;
      ST_DROP:    inReady = 1'b1;
      ST_DA_WR:   inReady = 1'b0;
      ST_SA,
      ST_LEN,
      ST_PAYLOAD: inReady = !bus.fifo_full[sel_q];
      default:    inReady = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && inReady;

  // Next-state and write-bus logic. Every branch only acts on an accepted
  // byte (except DA_WR, which waits on FIFO space), so a low in_valid holds
  // state, length and port selection untouched. fifo_data is forced to zero
  // whenever no strobe is raised.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    da_d     = da_q;
    lenCnt_d = lenCnt_q;
    hdrIdx_d = hdrIdx_q;
    wrEn     = '0;
    wrData   = '0;
    fwdInc   = 1'b0;
    dropInc  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          da_d     = bus.in_data;
          sel_d    = daSel;
          hdrIdx_d = HDR_SA;
          state_d  = daMatch ? ST_DA_WR : ST_DROP;
        end
      end

      ST_DA_WR: begin
        if (!bus.fifo_full[sel_q]) begin
          wrEn[sel_q] = 1'b1;
          wrData      = da_q;
          state_d     = ST_SA;
        end
      end

      ST_SA: begin
        if (accept) begin
          wrEn[sel_q] = 1'b1;
          wrData      = bus.in_data;
          state_d     = ST_LEN;
        end
      end

      ST_LEN: begin
        if (accept) begin
          wrEn[sel_q] = 1'b1;
          wrData      = bus.in_data;
          lenCnt_d    = bus.in_data;
          if (bus.in_data == '0) begin
            state_d = ST_IDLE;
            fwdInc  = 1'b1;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (accept) begin
          wrEn[sel_q] = 1'b1;
          wrData      = bus.in_data;
          lenCnt_d    = lenCnt_q - W_WIDTH'(1);
          if (lenCnt_q == W_WIDTH'(1)) begin
            state_d = ST_IDLE;
            fwdInc  = 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (accept) begin
          unique case (hdrIdx_q)
            HDR_SA: begin
              hdrIdx_d = HDR_LEN;
            end
            HDR_LEN: begin
              lenCnt_d = bus.in_data;
              if (bus.in_data == '0) begin
                state_d = ST_IDLE;
                dropInc = 1'b1;
              end else begin
                hdrIdx_d = HDR_BODY;
              end
            end
            default: begin
              lenCnt_d = lenCnt_q - W_WIDTH'(1);
              if (lenCnt_q == W_WIDTH'(1)) begin
                state_d = ST_IDLE;
                dropInc = 1'b1;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset may land mid-packet; whatever was
  // already written to a FIFO is left for the FIFO side to discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      da_q     <= '0;
      lenCnt_q <= '0;
      hdrIdx_q <= HDR_DA;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      da_q     <= da_d;
      lenCnt_q <= lenCnt_d;
      hdrIdx_q <= hdrIdx_d;
    end
  end

  // Packet counters hold at all-ones rather than wrapping, so a long run
  // never makes the statistics look smaller than they are.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwdCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      if (fwdInc && (fwdCnt_q != {CNT_WIDTH{1'b1}})) begin
        fwdCnt_q <= fwdCnt_q + CNT_WIDTH'(1);
      end
      if (dropInc && (dropCnt_q != {CNT_WIDTH{1'b1}})) begin
        dropCnt_q <= dropCnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.fifo_wr_en = wrEn;
  assign bus.fifo_data  = wrData;
  assign busy           = (state_q != ST_IDLE);
  assign fwd_cnt        = fwdCnt_q;
  assign drop_cnt       = dropCnt_q;

endmodule

// File: tb/tb_switch_ingress_router.sv
// ----------------------------------------------------------------------------
// tb_switch_ingress_router
// Directed self-checking bench for switch_ingress_router. A negedge monitor
// collects every FIFO write into a per-port queue; the directed sequence
// then compares those queues and the counters with hand-computed packets.
// ----------------------------------------------------------------------------
module tb_switch_ingress_router;
  import switch_pkg::*;

  localparam int NUM_PORTS = 4;
  localparam int W_WIDTH   = 8;
  localparam int CNT_WIDTH = 16;

  logic                         clk;
  logic                         rst_n;
  logic [NUM_PORTS*W_WIDTH-1:0] portAddr;
  logic                         busy;
  logic [CNT_WIDTH-1:0]         fwdCnt;
  logic [CNT_WIDTH-1:0]         dropCnt;

  int testsRun  = 0;
  int failCount = 0;
  int stallCycles = 0;
  int cycleCount  = 0;
  int startCycle;

  logic [7:0] obs [NUM_PORTS][$];
  logic [7:0] expQ [$];

  switch_ingress_router_if #(.NUM_PORTS(NUM_PORTS), .W_WIDTH(W_WIDTH)) bus ();

  switch_ingress_router #(
    .NUM_PORTS (NUM_PORTS),
    .W_WIDTH   (W_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .port_addr (portAddr),
    .busy      (busy),
    .fwd_cnt   (fwdCnt),
    .drop_cnt  (dropCnt)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure packet throughput.
  always @(posedge clk) begin
    cycleCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor on the falling edge: record writes that the next rising edge
  // commits, count stalled cycles, and police the write-bus invariants.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.fifo_wr_en[i]) obs[i].push_back(bus.fifo_data);
    end
    if (bus.in_valid && !bus.in_ready) stallCycles++;
    checkOutput("wr_en_onehot", 32'($countones(bus.fifo_wr_en) <= 1), 32'd1);
    if (bus.fifo_wr_en == '0) checkOutput("data_zero_no_wr", 32'(bus.fifo_data), 32'd0);
  end

  // Present one byte and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    int waitCycles;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    waitCycles   = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waitCycles++;
      if (waitCycles > 50) begin
        checkOutput("accept_timeout", 32'(b), 32'hFFFF_FFFF);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sendPacket(input logic [7:0] da, input logic [7:0] sa,
                            input logic [7:0] len, input logic [7:0] p0,
                            input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3);
    logic [7:0] pl [4];
    pl = '{p0, p1, p2, p3};
    applyStimulus(da);
    applyStimulus(sa);
    applyStimulus(len);
    for (int i = 0; i < int'(len) && i < 4; i++) applyStimulus(pl[i]);
  endtask

  task automatic idleCycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearObs();
    for (int i = 0; i < NUM_PORTS; i++) obs[i].delete();
  endtask

  // Compare one port's captured writes with expQ and require every other
  // port to have seen nothing.
  task automatic checkFifo(input string tag, input int port);
    checkOutput({tag, "_count"}, 32'(obs[port].size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < obs[port].size()) checkOutput({tag, "_byte"}, 32'(obs[port][i]), 32'(expQ[i]));
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (j != port) checkOutput({tag, "_other_empty"}, 32'(obs[j].size()), 32'd0);
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.fifo_full  = '0;
    portAddr       = packPortAddr();
    #1 rst_n = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    checkOutput("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fwd_cnt", 32'(fwdCnt), 32'd0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(1);

    // T1: packet to port 1, valid held high, single DA_WR bubble
    clearObs();
    stallCycles = 0;
    sendPacket(8'h20, 8'h01, 8'd3, 8'hAA, 8'hBB, 8'hCC, 8'h00);
    idleCycles(2);
    expQ = '{8'h20, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    checkFifo("t1_fifo1", 1);
    checkOutput("t1_fwd_cnt", 32'(fwdCnt), 32'd1);
    checkOutput("t1_stall_cycles", 32'(stallCycles), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd0);

    // T2: unmatched DA is consumed without stalls or writes
    clearObs();
    stallCycles = 0;
    sendPacket(8'h55, 8'h01, 8'd2, 8'h11, 8'h22, 8'h00, 8'h00);
    idleCycles(2);
    for (int j = 0; j < NUM_PORTS; j++) checkOutput("t2_no_write", 32'(obs[j].size()), 32'd0);
    checkOutput("t2_stall_cycles", 32'(stallCycles), 32'd0);
    checkOutput("t2_drop_cnt", 32'(dropCnt), 32'd1);
    checkOutput("t2_fwd_cnt", 32'(fwdCnt), 32'd1);
    checkOutput("t2_busy", 32'(busy), 32'd0);

    // T3: FIFO0 full for 3 cycles while payload byte 2 is offered
    clearObs();
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h04);
    applyStimulus(8'hA1);
    bus.fifo_full = 4'b0001;
    bus.in_data   = 8'hA2;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("t3_full_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.fifo_full = '0;
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    applyStimulus(8'hA4);
    idleCycles(2);
    expQ = '{8'h10, 8'h02, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    checkFifo("t3_fifo0", 0);
    checkOutput("t3_fwd_cnt", 32'(fwdCnt), 32'd2);
    checkOutput("t3_drop_cnt", 32'(dropCnt), 32'd1);

    // T4: LEN=0 packet to port 3 then LEN=1 packet to port 2, back to back.
    // 7 bytes plus 2 DA_WR bubbles take 9 clocks.
    clearObs();
    startCycle = cycleCount;
    sendPacket(8'h40, 8'h03, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    sendPacket(8'h30, 8'h04, 8'd1, 8'h77, 8'h00, 8'h00, 8'h00);
    checkOutput("t4_cycles", 32'(cycleCount - startCycle), 32'd9);
    idleCycles(2);
    checkOutput("t4_fifo3_count", 32'(obs[3].size()), 32'd3);
    checkOutput("t4_fifo2_count", 32'(obs[2].size()), 32'd4);
    if (obs[3].size() == 3) begin
      checkOutput("t4_fifo3_b0", 32'(obs[3][0]), 32'h40);
      checkOutput("t4_fifo3_b2", 32'(obs[3][2]), 32'h00);
    end
    if (obs[2].size() == 4) begin
      checkOutput("t4_fifo2_b0", 32'(obs[2][0]), 32'h30);
      checkOutput("t4_fifo2_b3", 32'(obs[2][3]), 32'h77);
    end
    checkOutput("t4_fifo0_empty", 32'(obs[0].size()), 32'd0);
    checkOutput("t4_fifo1_empty", 32'(obs[1].size()), 32'd0);
    checkOutput("t4_fwd_cnt", 32'(fwdCnt), 32'd4);

    // T5: asynchronous reset in the middle of a payload
    applyStimulus(8'h20);
    applyStimulus(8'h05);
    applyStimulus(8'h03);
    applyStimulus(8'hE1);
    bus.in_data  = 8'hE2;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t5_pre_rst_wr_en", 32'(bus.fifo_wr_en), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    checkOutput("t5_rst_fifo_data", 32'(bus.fifo_data), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("t5_fwd_cnt_zero", 32'(fwdCnt), 32'd0);
    checkOutput("t5_drop_cnt_zero", 32'(dropCnt), 32'd0);
    idleCycles(1);
    clearObs();
    sendPacket(8'h30, 8'h06, 8'd1, 8'h99, 8'h00, 8'h00, 8'h00);
    idleCycles(2);
    expQ = '{8'h30, 8'h06, 8'h01, 8'h99};
    checkFifo("t5_fifo2", 2);
    checkOutput("t5_fwd_cnt", 32'(fwdCnt), 32'd1);

    // T6: duplicated address resolves to the lowest port; valid toggles
    portAddr[1*W_WIDTH +: W_WIDTH] = 8'h33;
    portAddr[2*W_WIDTH +: W_WIDTH] = 8'h33;
    idleCycles(1);
    clearObs();
    expQ = '{8'h33, 8'h07, 8'h02, 8'h5A, 8'h5B};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(expQ[i]);
      bus.in_valid = 1'b0;
      @(negedge clk);
      if (i >= 1) begin
        checkOutput("t6_gap_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        checkOutput("t6_gap_busy", 32'(busy), 32'(i < 4));
      end
      @(posedge clk);
      #1;
    end
    idleCycles(1);
    checkFifo("t6_fifo1", 1);
    checkOutput("t6_fwd_cnt", 32'(fwdCnt), 32'd2);
    checkOutput("t6_drop_cnt", 32'(dropCnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
